// File: rtl/fb_write_arbiter_if.sv
// Pixel-write bus between three requesters, the arbiter and the framebuffer.
// The slave side is the arbiter; the master side drives requests and FB_READY.
interface fb_write_arbiter_if;
    logic       REQ0_VALID, REQ1_VALID, REQ2_VALID;
    logic       REQ0_READY, REQ1_READY, REQ2_READY;
    logic [7:0] REQ0_X, REQ0_Y, REQ1_X, REQ1_Y, REQ2_X, REQ2_Y;
    logic [2:0] REQ0_R, REQ0_G, REQ0_B;
    logic [2:0] REQ1_R, REQ1_G, REQ1_B;
    logic [2:0] REQ2_R, REQ2_G, REQ2_B;
    logic       FB_READY;
    logic [7:0] X, Y;
    logic [2:0] R, G, B;
    logic       WE;
    logic [1:0] OWNER;
    logic [15:0] CLIP_CNT;

    modport slave (
        input  REQ0_VALID, REQ1_VALID, REQ2_VALID,
        input  REQ0_X, REQ0_Y, REQ1_X, REQ1_Y, REQ2_X, REQ2_Y,
        input  REQ0_R, REQ0_G, REQ0_B,
        input  REQ1_R, REQ1_G, REQ1_B,
        input  REQ2_R, REQ2_G, REQ2_B,
        input  FB_READY,
        output REQ0_READY, REQ1_READY, REQ2_READY,
        output X, Y, R, G, B, WE, OWNER, CLIP_CNT
    );

    modport master (
        output REQ0_VALID, REQ1_VALID, REQ2_VALID,
        output REQ0_X, REQ0_Y, REQ1_X, REQ1_Y, REQ2_X, REQ2_Y,
        output REQ0_R, REQ0_G, REQ0_B,
        output REQ1_R, REQ1_G, REQ1_B,
        output REQ2_R, REQ2_G, REQ2_B,
        output FB_READY,
        input  REQ0_READY, REQ1_READY, REQ2_READY,
        input  X, Y, R, G, B, WE, OWNER, CLIP_CNT
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Three-way round-robin burst arbiter feeding one registered framebuffer write port.
// Optional clip window enabled by defining FB_ARB_CLIP_EN.
module fb_write_arbiter #(
    parameter int BURST_LEN = 16,
    parameter int CLIP_X0   = 0,
    parameter int CLIP_X1   = 255,
    parameter int CLIP_Y0   = 0,
    parameter int CLIP_Y1   = 255
) (
    input logic              CLK,
    input logic              NRST,
    fb_write_arbiter_if.slave bus
);
    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    if (BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_burst
        $error("fb_write_arbiter: BURST_LEN must be 1..255");
    end
    if (CLIP_X0 < 0 || CLIP_X1 > 255 || CLIP_X0 > CLIP_X1 ||
        CLIP_Y0 < 0 || CLIP_Y1 > 255 || CLIP_Y0 > CLIP_Y1) begin : g_bad_clip
        $error("fb_write_arbiter: clip window out of range");
    end

    logic [0:0] state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_q, owner_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] x_q, x_d, y_q, y_d;
    logic [2:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic       we_q, we_d;

    logic [2:0] vld;
    logic       slot_free;
    logic [1:0] c0, c1, c2;
    logic [1:0] win;
    logic       win_ok;
    logic       own_vld;
    logic [2:0] gnt;
    logic       xfer;
    logic [1:0] gidx;
    logic [7:0] px_x, px_y;
    logic [2:0] px_r, px_g, px_b;
    logic       px_keep;

    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign vld       = {bus.REQ2_VALID, bus.REQ1_VALID, bus.REQ0_VALID};
    assign slot_free = !we_q || bus.FB_READY;
    assign c0        = ptr_q;
    assign c1        = inc3(c0);
    assign c2        = inc3(c1);
    assign own_vld   = vld[owner_q];

    // Round-robin search starting at ptr_q.
    always_comb begin
        win    = c0;
        win_ok = 1'b1;
        if (vld[c0])      win = c0;
        else if (vld[c1]) win = c1;
        else if (vld[c2]) win = c2;
        else              win_ok = 1'b0;
    end

    always_comb begin
        gnt = 3'b000;
        if (NRST && slot_free) begin
            unique case (state_q)
                ARB:     if (win_ok)  gnt = 3'b001 << win;
                HOLD:    if (own_vld) gnt = 3'b001 << owner_q;
                default: gnt = 3'b000;
            endcase
        end
    end

    assign xfer = |gnt;
    assign gidx = (state_q == HOLD) ? owner_q : win;

    always_comb begin
        unique case (gidx)
            2'd0: begin
                px_x = bus.REQ0_X; px_y = bus.REQ0_Y;
                px_r = bus.REQ0_R; px_g = bus.REQ0_G; px_b = bus.REQ0_B;
            end
            2'd1: begin
                px_x = bus.REQ1_X; px_y = bus.REQ1_Y;
                px_r = bus.REQ1_R; px_g = bus.REQ1_G; px_b = bus.REQ1_B;
            end
            default: begin
                px_x = bus.REQ2_X; px_y = bus.REQ2_Y;
                px_r = bus.REQ2_R; px_g = bus.REQ2_G; px_b = bus.REQ2_B;
            end
        endcase
    end

`ifdef FB_ARB_CLIP_EN
    logic [15:0] clip_q, clip_d;
    int          xi, yi;

    always_comb begin
        xi      = int'(px_x);
        yi      = int'(px_y);
        px_keep = (xi >= CLIP_X0) && (xi <= CLIP_X1) &&
                  (yi >= CLIP_Y0) && (yi <= CLIP_Y1);
        clip_d  = clip_q;
        if (xfer && !px_keep && clip_q != 16'hFFFF)
            clip_d = clip_q + 16'd1;
    end

    always_ff @(posedge CLK) begin
        if (!NRST) clip_q <= '0;
        else       clip_q <= clip_d;
    end

    assign bus.CLIP_CNT = clip_q;
`else
    assign px_keep      = 1'b1;
    assign bus.CLIP_CNT = '0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ARB: begin
                if (xfer) begin
                    owner_d = win;
                    cnt_d   = 8'd1;
                    if (BURST_LEN > 1) state_d = HOLD;
                    else               ptr_d   = inc3(win);
                end
            end
            HOLD: begin
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == 8'(BURST_LEN)) begin
                        state_d = ARB;
                        ptr_d   = inc3(owner_q);
                    end
                end else if (!own_vld) begin
                    state_d = ARB;
                    ptr_d   = inc3(owner_q);
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Output register: load on transfer, drain when the slot frees up.
    always_comb begin
        x_d  = x_q;
        y_d  = y_q;
        r_d  = r_q;
        g_d  = g_q;
        b_d  = b_q;
        we_d = we_q;
        if (xfer) begin
            x_d  = px_x;
            y_d  = px_y;
            r_d  = px_r;
            g_d  = px_g;
            b_d  = px_b;
            we_d = px_keep;
        end else if (slot_free) begin
            we_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!NRST) begin
            state_q <= ARB;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            we_q    <= we_d;
        end
    end

    assign bus.REQ0_READY = gnt[0];
    assign bus.REQ1_READY = gnt[1];
    assign bus.REQ2_READY = gnt[2];
    assign bus.X          = x_q;
    assign bus.Y          = y_q;
    assign bus.R          = r_q;
    assign bus.G          = g_q;
    assign bus.B          = b_q;
    assign bus.WE         = we_q;
    assign bus.OWNER      = owner_q;
endmodule

// File: doc/fb_write_arbiter.md
FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 16, max consecutive beats one requester may hold the grant (legal 1..255).
REQ-002 Parameters CLIP_X0 / CLIP_X1 / CLIP_Y0 / CLIP_Y1, defaults 0 / 255 / 0 / 255, inclusive clip window (used only with FB_ARB_CLIP_EN).
REQ-003 CLK  in  1  clock; all logic on rising edge.
REQ-004 NRST  in  1  reset, synchronous, active-low.
REQ-005 REQn_VALID  in  1  requester n (n=0,1,2) presents a pixel write.
REQ-006 REQn_READY  out  1  pixel of requester n accepted this cycle.
REQ-007 REQn_X, REQn_Y  in  8 each  pixel address of requester n.
REQ-008 REQn_R, REQn_G, REQn_B  in  3 each  pixel colour of requester n.
REQ-009 FB_READY  in  1  framebuffer consumes the output pixel this cycle.
REQ-010 X, Y  out  8 each  registered framebuffer write address.
REQ-011 R, G, B  out  3 each  registered framebuffer write colour.
REQ-012 WE  out  1  registered write strobe; X/Y/R/G/B valid while high.
REQ-013 OWNER  out  2  index of current/last granted requester.
REQ-014 CLIP_CNT  out  16  count of clipped beats (see Configuration).

Function
REQ-015 Output slot free when WE=0 or FB_READY=1; transfer from requester n occurs when REQn_VALID and REQn_READY are both high.
REQ-016 REQn_READY shall be high only for the granted requester and only when the slot is free; at most one READY high per cycle.
REQ-017 REQn_READY may depend combinationally on VALID and FB_READY; no output shall depend combinationally on itself.
REQ-018 Accepted pixel appears on X/Y/R/G/B with WE=1 on the next cycle (latency 1); held unchanged while WE=1 and FB_READY=0.
REQ-019 Slot free with no transfer: WE clears to 0 next cycle.
REQ-020 FSM states ARB and HOLD; reset state ARB.
REQ-021 ARB: if slot free and any VALID, grant the first valid requester searching from PTR upward, wrapping 2->0, transfer that cycle, OWNER<=winner, beat count<=1.
REQ-022 ARB -> HOLD after a transfer when BURST_LEN>1; stays ARB (PTR<=winner+1 mod 3) when BURST_LEN=1.
REQ-023 HOLD: only OWNER may be granted; each transfer increments beat count.
REQ-024 HOLD -> ARB, PTR<=OWNER+1 mod 3, when a transfer brings beat count to BURST_LEN, or when REQ[OWNER]_VALID is low in a cycle (no transfer that cycle).
REQ-025 HOLD with owner VALID high but slot not free: stay HOLD, count unchanged.
REQ-026 Non-owner VALID in HOLD shall wait; its data is not sampled.

Reset
REQ-027 NRST=0 at a rising edge: WE=0, X=Y=0, R=G=B=0, OWNER=0, PTR=0, beat count=0, CLIP_CNT=0, state ARB; all READY low that cycle.
REQ-028 Reset mid-burst or with WE=1 shall discard the pending pixel; no write is issued after reset release until a new transfer.

Configuration
REQ-029 Macro FB_ARB_CLIP_EN defined: accepted beat with X outside [CLIP_X0,CLIP_X1] or Y outside [CLIP_Y0,CLIP_Y1] is acknowledged, counts toward the burst, produces WE=0, and increments CLIP_CNT (saturating at 16'hFFFF).
REQ-030 FB_ARB_CLIP_EN undefined: no clipping, every accepted beat is written, CLIP_CNT tied to 0, CLIP_* parameters unused.

Verification
REQ-031 Reset, then only REQ0 valid with X=5,Y=7,RGB=7/0/3, FB_READY=1 -> next cycle WE=1, X=5, Y=7, R=7, G=0, B=3, OWNER=0.
REQ-032 All three VALID continuously, BURST_LEN=16, FB_READY=1 -> 16 beats REQ0, 16 REQ1, 16 REQ2, then REQ0; never two READYs high.
REQ-033 REQ1 owner, FB_READY=0 for 4 cycles after WE=1 -> X/Y/RGB stable, all READY low, then transfer resumes with no lost or duplicated pixel.
REQ-034 REQ2 owner drops VALID after 3 beats while REQ0 valid -> one idle cycle, then REQ0 granted (wrap 2->0), OWNER=0.
REQ-035 FB_ARB_CLIP_EN, CLIP_X1=99, REQ0 writes X=100 then X=99 -> first beat READY=1, WE stays 0, CLIP_CNT=1; second beat written WE=1, X=99.
REQ-036 NRST low during HOLD with WE=1 -> WE=0, OWNER=0, CLIP_CNT=0; after release REQ0 granted first.
